// File: rtl/mmio_pkg.sv
// mmio_pkg: address map and read-source encoding shared by the load/store bridge
package mmio_pkg;
  localparam logic [15:0] RAM_TOP      = 16'h7FFF;
  localparam logic [15:0] MMIO_LED     = 16'hA000;
  localparam logic [15:0] MMIO_SW      = 16'hA002;
  localparam logic [15:0] MMIO_TCOUNT  = 16'hA004;
  localparam logic [15:0] MMIO_TCTRL   = 16'hA006;
  localparam logic [15:0] MMIO_TRELOAD = 16'hA008;
  typedef enum logic [1:0] {RD_NONE, RD_RAM, RD_PERIPH} rd_src_t;
endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: prescaled down-counting timer with reload and sticky expired flag
module mmio_timer #(
  parameter int PRESCALE = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] wdata,
  input  logic        wr_count,
  input  logic        wr_ctrl,
  input  logic        wr_reload,
  output logic [15:0] count,
  output logic [15:0] reload,
  output logic [15:0] ctrl,
  output logic        irq
);
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
  logic [15:0] pre;
  logic        en;
  logic        flag;
  logic        tick;
  logic        expire;
  assign tick   = en && pre == 16'd0;
  // a TCOUNT write swallows the tick, so it cannot expire in that cycle
  assign expire = tick && count == 16'd0 && !wr_count;
  assign ctrl   = {14'd0, flag, en};
  assign irq    = flag;
  always_ff @(posedge clk) begin
    if (reset) begin
      pre    <= PRE_MAX;
      count  <= '0;
      reload <= '0;
      en     <= 1'b0;
      flag   <= 1'b0;
    end else begin
      pre   <= (wr_count || !en || pre == 16'd0) ? PRE_MAX : pre - 16'd1;
      count <= wr_count ? wdata : tick ? (count == 16'd0 ? reload : count - 16'd1) : count;
      if (wr_reload) reload <= wdata;
      if (wr_ctrl) en <= wdata[0];
      flag  <= expire | (flag & ~(wr_ctrl & wdata[1]));
    end
  end
endmodule

// File: rtl/ldst_bridge.sv
// ldst_bridge: routes CPU loads/stores to RAM or on-chip peripherals with fixed 1-cycle read latency
module ldst_bridge
  import mmio_pkg::*;
#(
  parameter int PRESCALE = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_ldst_addr,
  input  logic        i_ldst_rd,
  input  logic        i_ldst_wr,
  input  logic [15:0] i_ldst_wrdata,
  output logic [15:0] o_ldst_rddata,
  output logic [14:0] o_ram_addr,
  output logic        o_ram_rd,
  output logic        o_ram_wr,
  output logic [15:0] o_ram_wrdata,
  input  logic [15:0] i_ram_rddata,
  output logic [15:0] o_leds,
  input  logic [15:0] i_switches,
  output logic        o_timer_irq
);
  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [15:0] rd_buf;
  logic [15:0] periph_data;
  logic [15:0] t_count;
  logic [15:0] t_reload;
  logic [15:0] t_ctrl;
  logic        is_ram;
  rd_src_t     rd_sel;
  assign is_ram       = i_ldst_addr <= RAM_TOP;
  assign o_ram_addr   = i_ldst_addr[14:0];
  assign o_ram_rd     = i_ldst_rd & is_ram;
  assign o_ram_wr     = i_ldst_wr & is_ram;
  assign o_ram_wrdata = i_ldst_wrdata;
  always_comb begin
    periph_data = i_ldst_addr == MMIO_LED     ? o_leds   :
                  i_ldst_addr == MMIO_SW      ? sw_sync  :
                  i_ldst_addr == MMIO_TCOUNT  ? t_count  :
                  i_ldst_addr == MMIO_TCTRL   ? t_ctrl   :
                  i_ldst_addr == MMIO_TRELOAD ? t_reload : '0;
    o_ldst_rddata = rd_sel == RD_RAM    ? i_ram_rddata :
                    rd_sel == RD_PERIPH ? rd_buf       : '0;
  end
  // rd_buf samples registers before this edge's writes, so load+store returns the old value
  always_ff @(posedge clk) begin
    if (reset) begin
      o_leds  <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
      rd_buf  <= '0;
      rd_sel  <= RD_NONE;
    end else begin
      sw_meta <= i_switches;
      sw_sync <= sw_meta;
      if (i_ldst_wr && i_ldst_addr == MMIO_LED) o_leds <= i_ldst_wrdata;
      if (i_ldst_rd) begin
        rd_sel <= is_ram ? RD_RAM : RD_PERIPH;
        rd_buf <= periph_data;
      end
    end
  end
  mmio_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .wdata     (i_ldst_wrdata),
    .wr_count  (i_ldst_wr && i_ldst_addr == MMIO_TCOUNT),
    .wr_ctrl   (i_ldst_wr && i_ldst_addr == MMIO_TCTRL),
    .wr_reload (i_ldst_wr && i_ldst_addr == MMIO_TRELOAD),
    .count     (t_count),
    .reload    (t_reload),
    .ctrl      (t_ctrl),
    .irq       (o_timer_irq)
  );
endmodule

// File: tb/tb_ldst_bridge.sv
// tb_ldst_bridge: directed plus random stimulus scored against a behavioural model of the bridge
module tb_ldst_bridge;
  import mmio_pkg::*;
  localparam int P = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] wrdata = '0;
  logic [15:0] rddata;
  logic [14:0] ram_addr;
  logic        ram_rd;
  logic        ram_wr;
  logic [15:0] ram_wrdata;
  logic [15:0] ram_q = '0;
  logic [15:0] leds;
  logic [15:0] switches = '0;
  logic        irq;
  always #5 clk = ~clk;
  ldst_bridge #(.PRESCALE(P)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_ldst_addr   (addr),
    .i_ldst_rd     (rd),
    .i_ldst_wr     (wr),
    .i_ldst_wrdata (wrdata),
    .o_ldst_rddata (rddata),
    .o_ram_addr    (ram_addr),
    .o_ram_rd      (ram_rd),
    .o_ram_wr      (ram_wr),
    .o_ram_wrdata  (ram_wrdata),
    .i_ram_rddata  (ram_q),
    .o_leds        (leds),
    .i_switches    (switches),
    .o_timer_irq   (irq)
  );
  logic [15:0] mem [0:16383];
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr[14:1]] <= ram_wrdata;
    if (ram_rd) ram_q <= mem[ram_addr[14:1]];
  end
  logic [15:0] m_ram [0:16383];
  logic [15:0] m_leds, m_sw1, m_sw2, m_count, m_reload, m_out;
  logic        m_en, m_flag;
  int          m_pre;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (a < 16'h8000) return m_ram[a[14:1]];
    case (a)
      MMIO_LED:     return m_leds;
      MMIO_SW:      return m_sw2;
      MMIO_TCOUNT:  return m_count;
      MMIO_TCTRL:   return {14'd0, m_flag, m_en};
      MMIO_TRELOAD: return m_reload;
      default:      return 16'h0000;
    endcase
  endfunction
  task automatic model_reset();
    m_leds = 0; m_sw1 = 0; m_sw2 = 0; m_count = 0; m_reload = 0;
    m_en = 0; m_flag = 0; m_pre = P - 1; m_out = 0;
  endtask
  task automatic model_step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d, input logic rst);
    bit tick, wc, wt, wl, expire, clr;
    if (w && a < 16'h8000) m_ram[a[14:1]] = d;
    if (rst) begin
      model_reset();
      return;
    end
    tick   = m_en && m_pre == 0;
    wc     = w && a == MMIO_TCOUNT;
    wt     = w && a == MMIO_TCTRL;
    wl     = w && a == MMIO_TRELOAD;
    expire = tick && m_count == 0 && !wc;
    clr    = wt && d[1];
    m_flag = expire || (m_flag && !clr);
    if (wc) m_count = d;
    else if (tick) m_count = (m_count == 0) ? m_reload : m_count - 16'd1;
    m_pre = (wc || !m_en || m_pre == 0) ? P - 1 : m_pre - 1;
    if (wl) m_reload = d;
    if (wt) m_en = d[0];
    if (w && a == MMIO_LED) m_leds = d;
    m_sw2 = m_sw1;
    m_sw1 = switches;
  endtask
  // drives one CPU cycle; returns 1 time unit after the clock edge
  task automatic cycle(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d, input logic rst);
    rd = r; wr = w; addr = a; wrdata = d; reset = rst;
    #1;
    check("ram_rd", {15'd0, ram_rd}, {15'd0, r & ~a[15]});
    check("ram_wr", {15'd0, ram_wr}, {15'd0, w & ~a[15]});
    if (r || w) check("ram_addr", {1'b0, ram_addr}, {1'b0, a[14:0]});
    if (w) check("ram_wrdata", ram_wrdata, d);
    m_out = rst ? 16'h0 : r ? m_read(a) : m_out;
    exp_q.push_back(m_out);
    @(posedge clk);
    model_step(r, w, a, d, rst);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      check("rddata", rddata, exp_q.pop_front());
      check("leds", leds, m_leds);
      check("irq", {15'd0, irq}, {15'd0, m_flag});
    end
  end
  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] = '0;
      m_ram[i] = '0;
    end
    model_reset();
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    cycle(1'b1, 1'b0, MMIO_TCTRL, 16'h0, 1'b0);
    idle(1);
    cycle(1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0);
    cycle(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
    idle(1);
    check("ram_read_0010", rddata, 16'h1234);
    cycle(1'b0, 1'b1, MMIO_LED, 16'h00FF, 1'b0);
    cycle(1'b1, 1'b1, MMIO_LED, 16'h0F0F, 1'b0);
    check("led_load_old", rddata, 16'h00FF);
    check("led_after_store", leds, 16'h0F0F);
    cycle(1'b1, 1'b0, 16'hB000, 16'h0, 1'b0);
    check("unmapped_read", rddata, 16'h0000);
    cycle(1'b0, 1'b1, MMIO_TRELOAD, 16'h2, 1'b0);
    cycle(1'b0, 1'b1, MMIO_TCOUNT, 16'h2, 1'b0);
    cycle(1'b0, 1'b1, MMIO_TCTRL, 16'h1, 1'b0);
    idle(11);
    check("irq_before_12", {15'd0, irq}, 16'd0);
    idle(1);
    check("irq_at_12", {15'd0, irq}, 16'd1);
    cycle(1'b1, 1'b0, MMIO_TCOUNT, 16'h0, 1'b0);
    check("tcount_reloaded", rddata, 16'h2);
    cycle(1'b0, 1'b1, MMIO_TCTRL, 16'h3, 1'b0);
    check("irq_cleared", {15'd0, irq}, 16'd0);
    idle(9);
    check("irq_before_24", {15'd0, irq}, 16'd0);
    cycle(1'b0, 1'b1, MMIO_TCTRL, 16'h3, 1'b0);
    check("irq_set_wins", {15'd0, irq}, 16'd1);
    cycle(1'b0, 1'b1, MMIO_TCTRL, 16'h3, 1'b0);
    check("irq_late_clear", {15'd0, irq}, 16'd0);
    cycle(1'b0, 1'b1, MMIO_TCTRL, 16'h0, 1'b0);
    switches = 16'hA5A5;
    idle(1);
    cycle(1'b1, 1'b0, MMIO_SW, 16'h0, 1'b0);
    check("sw_old", rddata, 16'h0000);
    cycle(1'b1, 1'b0, MMIO_SW, 16'h0, 1'b0);
    check("sw_new", rddata, 16'hA5A5);
    cycle(1'b1, 1'b0, MMIO_LED, 16'h0, 1'b1);
    check("reset_load", rddata, 16'h0000);
    check("reset_leds", leds, 16'h0000);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a, d;
      case ($urandom_range(0, 9))
        0, 1, 2: a = 16'($urandom_range(0, 63) * 2);
        3: a = MMIO_LED;
        4: a = MMIO_SW;
        5: a = MMIO_TCOUNT;
        6: a = MMIO_TCTRL;
        7: a = MMIO_TRELOAD;
        8: a = 16'hB000;
        default: a = 16'hA00A;
      endcase
      d = 16'($urandom);
      if (a == MMIO_TCOUNT || a == MMIO_TRELOAD) d = d & 16'h7;
      if ($urandom_range(0, 7) == 0) switches = 16'($urandom);
      cycle(1'($urandom), 1'($urandom_range(0, 2) == 0), a, d, 1'($urandom_range(0, 99) == 0));
    end
    idle(2);
    @(negedge clk);
    #1;
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
